ca_step_sequencer: RTL
======================

# ca_step_sequencer

Sequencer for the 8-cell, 4-bit-rule cellular-automaton update used by the CA2 datapath. Each next cell is next[i] = rule[{s[(i+1) mod 8], s[i]}], wrapping cell 7 to cell 0. The block captures a seed, rule and generation count on a start request, then advances the state one generation per clock. It stops at the requested count, or early on a fixed point when enabled, and reports completion. It sits between a host that issues jobs and the combinational rule-evaluation logic, which it embeds.

## Interface
- W, 8, cell count / state width (behaviour below is specified and verified at 8)
- CW, 8, width of step count and generation counter
- clk  in  1  system clock, all state changes on rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  job request, sampled only in IDLE
- seed  in  W  initial state, captured with start
- rule  in  4  rule table, captured with start
- steps  in  CW  generations to run, captured with start
- halt_on_fixed  in  1  early-stop enable, captured with start
- abort  in  1  cancel a running job, honoured only in RUN
- busy  out  1  high in RUN
- done  out  1  one-cycle completion pulse
- fixed  out  1  last job ended on a fixed point, held until next start
- state_out  out  W  current CA state
- gen_count  out  CW  generations applied in the current or last job

## Operation
- States: IDLE, RUN, DONE.
- Reset (reset_n=0 at an edge) forces IDLE and sets busy, done, fixed, state_out and gen_count all to 0. Captured rule, steps and halt_on_fixed registers also clear to 0.
- Reset overrides every other input, including mid-RUN; no done is produced for a job cut off by reset.
- IDLE, start=1:
  - capture rule, steps and halt_on_fixed;
  - load state_out←seed, gen_count←0, fixed←0;
  - go to RUN.
- IDLE, start=0: hold all outputs.
- RUN evaluates these conditions in priority order:
  1. abort=1: go to IDLE. state_out and gen_count hold; no done; fixed stays 0.
  2. gen_count==steps: go to DONE.
  3. halt_on_fixed=1 and next==state_out: fixed←1; go to DONE. gen_count is not incremented.
  4. Otherwise: state_out←next, gen_count←gen_count+1.
- DONE: done=1 for exactly this one cycle, then go to IDLE unconditionally. start is ignored in DONE.
- Inputs seed, rule, steps and halt_on_fixed are don't-care outside the start cycle; changing them mid-job has no effect.
- start is ignored in RUN and DONE; it is not queued.
- abort is ignored in IDLE and DONE. If start=1 and abort=1 arrive together in IDLE, start is accepted.
- gen_count never wraps, because it stops at steps ≤ 2^CW−1. steps=0 is legal and completes with state_out=seed.
- The fixed-point check applies even on the first generation: a seed that is already a fixed point stops immediately with gen_count=0.

## Timing
- start sampled at edge 0 → RUN from edge 0. Updates occur at edges 1..N, where N = the number of generations applied.
- DONE is entered at edge N+1, so done is high in the cycle after edge N+1, i.e. N+2 cycles after start is sampled.
- state_out and gen_count are final when done is high and stay stable until the next accepted start.
- Back-to-back jobs: a new start is accepted the cycle after done (IDLE). Minimum job spacing is N+3 cycles.
- busy rises the cycle after start is sampled and falls in the same cycle that done rises.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset: assert reset_n=0 mid-RUN with steps=200 → next cycle IDLE; busy, done, fixed, state_out and gen_count all 0; no done pulse afterwards.
- Single step: seed=8'h01, rule=4'b0110 (XOR of neighbours), steps=1 → state_out=8'h81, gen_count=1, done 3 cycles after start, fixed=0.
- Rotate wrap: seed=8'h01, rule=4'b1100 (next[i]=s[i+1]), steps=8 → intermediate 8'h80, 8'h40, …; final 8'h01, gen_count=8, done 10 cycles after start.
- Fixed point: rule=4'b1010 (identity), seed=8'hA5, steps=50, halt_on_fixed=1 → done at cycle 2, gen_count=0, fixed=1, state_out=8'hA5. Same job with halt_on_fixed=0 → gen_count=50, fixed=0.
- Zero steps: seed=8'h3C, steps=0 → done at cycle 2, state_out=8'h3C, gen_count=0.
- Abort and ignore: rule=4'b1100, seed=8'h01, steps=100.
  - Pulse start again mid-RUN → ignored.
  - Assert abort after 3 updates → IDLE, state_out=8'h20, gen_count=3, no done.
  - start and abort together in IDLE → new job accepted.

Source files
------------

// File: rtl/ca_step_sequencer_if.sv
// Host-side job interface for the CA step sequencer: job request in, status and CA state out.
interface ca_step_sequencer_if #(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 8
);
    logic          start;
    logic [W-1:0]  seed;
    logic [3:0]    rule;
    logic [CW-1:0] steps;
    logic          halt_on_fixed;
    logic          abort;
    logic          busy;
    logic          done;
    logic          fixed;
    logic [W-1:0]  state_out;
    logic [CW-1:0] gen_count;

    modport master (
        output start, seed, rule, steps, halt_on_fixed, abort,
        input  busy, done, fixed, state_out, gen_count
    );

    modport slave (
        input  start, seed, rule, steps, halt_on_fixed, abort,
        output busy, done, fixed, state_out, gen_count
    );
endinterface

// File: rtl/ca_step_sequencer.sv
// Runs a ring cellular automaton next[i] = rule[{s[i+1], s[i]}] for a captured number of
// generations, with optional early stop on a fixed point and a one-cycle done pulse.
module ca_step_sequencer #(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ca_step_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        fsm_q,   fsm_d;
    logic [3:0]    rule_q,  rule_d;
    logic [CW-1:0] steps_q, steps_d;
    logic          hof_q,   hof_d;
    logic [W-1:0]  cells_q, cells_d;
    logic [CW-1:0] gen_q,   gen_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;
    logic          fixed_q, fixed_d;
    logic [W-1:0]  next_cells;

    // Rule lookup per cell; the right neighbour of the top cell wraps to cell 0.
    for (genvar i = 0; i < int'(W); i++) begin : g_cell
        assign next_cells[i] = rule_q[{cells_q[(i + 1) % int'(W)], cells_q[i]}];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fsm_q   <= S_IDLE;
            rule_q  <= '0;
            steps_q <= '0;
            hof_q   <= 1'b0;
            cells_q <= '0;
            gen_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fixed_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            rule_q  <= rule_d;
            steps_q <= steps_d;
            hof_q   <= hof_d;
            cells_q <= cells_d;
            gen_q   <= gen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fixed_q <= fixed_d;
        end
    end

    // Next-state and next-output logic; every output is the registered copy of its _d value.
    always_comb begin
        fsm_d   = fsm_q;
        rule_d  = rule_q;
        steps_d = steps_q;
        hof_d   = hof_q;
        cells_d = cells_q;
        gen_d   = gen_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        fixed_d = fixed_q;

        unique case (fsm_q)
            S_IDLE: begin
                if (bus.start) begin
                    rule_d  = bus.rule;
                    steps_d = bus.steps;
                    hof_d   = bus.halt_on_fixed;
                    cells_d = bus.seed;
                    gen_d   = '0;
                    fixed_d = 1'b0;
                    busy_d  = 1'b1;
                    fsm_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    busy_d = 1'b0;
                    fsm_d  = S_IDLE;
                end else if (gen_q == steps_q) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    fsm_d  = S_DONE;
                end else if (hof_q && (next_cells == cells_q)) begin
                    fixed_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    fsm_d   = S_DONE;
                end else begin
                    cells_d = next_cells;
                    gen_d   = gen_q + CW'(1);
                end
            end
            S_DONE: begin
                fsm_d = S_IDLE;
            end
            default: begin
                busy_d = 1'b0;
                fsm_d  = S_IDLE;
            end
        endcase
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.fixed     = fixed_q;
    assign bus.state_out = cells_q;
    assign bus.gen_count = gen_q;

endmodule
